// File: rtl/traffic_phase_scheduler_if.sv
// Request inputs, lamp/walk outputs and debug phase of the NS/EW phase scheduler.
// EMERGENCY_PREEMPT_EN adds the emg_req / emg_dir preemption inputs.
interface traffic_phase_scheduler_if;
    logic       tick;
    logic       ns_req;
    logic       ew_req;
    logic       ns_ped_req;
    logic       ew_ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ns_walk;
    logic       ew_walk;
    logic [2:0] phase;
`ifdef EMERGENCY_PREEMPT_EN
    logic       emg_req;
    logic       emg_dir;

    modport master (output tick, ns_req, ew_req, ns_ped_req, ew_ped_req, emg_req, emg_dir,
                    input  ns_light, ew_light, ns_walk, ew_walk, phase);
    modport slave  (input  tick, ns_req, ew_req, ns_ped_req, ew_ped_req, emg_req, emg_dir,
                    output ns_light, ew_light, ns_walk, ew_walk, phase);
`else
    modport master (output tick, ns_req, ew_req, ns_ped_req, ew_ped_req,
                    input  ns_light, ew_light, ns_walk, ew_walk, phase);
    modport slave  (input  tick, ns_req, ew_req, ns_ped_req, ew_ped_req,
                    output ns_light, ew_light, ns_walk, ew_walk, phase);
`endif
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated NS/EW intersection phase scheduler advancing on a 1 Hz tick strobe.
// Define EMERGENCY_PREEMPT_EN to enable emergency-vehicle preemption.
module traffic_phase_scheduler #(
    parameter int MIN_GREEN    = 10,
    parameter int MAX_GREEN    = 30,
    parameter int YELLOW_TIME  = 5,
    parameter int ALL_RED_TIME = 2,
    parameter int WALK_TIME    = 8,
    parameter int TW           = 6
) (
    input logic                      clk,
    input logic                      rst_n,
    traffic_phase_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_TO_EW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_TO_NS = 3'd5
    } state_t;

    localparam logic [TW:0]   MIN_G  = (TW+1)'(MIN_GREEN);
    localparam logic [TW:0]   MAX_G  = (TW+1)'(MAX_GREEN);
    localparam logic [TW:0]   YEL_T  = (TW+1)'(YELLOW_TIME);
    localparam logic [TW:0]   RED_T  = (TW+1)'(ALL_RED_TIME);
    localparam logic [TW:0]   WALK_T = (TW+1)'(WALK_TIME);
    localparam logic [TW-1:0] MAX_C  = TW'(MAX_GREEN);
    localparam logic [TW-1:0] ZERO_C = {TW{1'b0}};

    state_t        state_r, state_s;
    logic [TW-1:0] cnt_r, cnt_s, grn_cnt_s;
    logic [TW:0]   nxt_s;
    logic          ns_ped_pend_r, ns_ped_pend_s, ew_ped_pend_r, ew_ped_pend_s;
    logic          walk_active_r, walk_active_s;
    logic          ns_dem_s, ew_dem_s, ns_go_s, ew_go_s;
    logic          ns_enter_s, ew_enter_s;
    logic          emg_to_ns_s, emg_to_ew_s, emg_on_s;

`ifdef EMERGENCY_PREEMPT_EN
    assign emg_to_ns_s = bus.emg_req & ~bus.emg_dir;
    assign emg_to_ew_s = bus.emg_req &  bus.emg_dir;
    assign emg_on_s    = bus.emg_req;
`else
    assign emg_to_ns_s = 1'b0;
    assign emg_to_ew_s = 1'b0;
    assign emg_on_s    = 1'b0;
`endif

    assign ns_dem_s  = bus.ns_req | ns_ped_pend_r;
    assign ew_dem_s  = bus.ew_req | ew_ped_pend_r;
    assign nxt_s     = {1'b0, cnt_r} + {{TW{1'b0}}, 1'b1};
    // Green count saturates so a long rest never wraps back below MIN_GREEN.
    assign grn_cnt_s = (nxt_s > MAX_G) ? MAX_C : nxt_s[TW-1:0];

    // An emergency toward the crossing road forces the green out; one toward this road pins it.
    assign ns_go_s = emg_to_ew_s | (~emg_to_ns_s & (nxt_s >= MIN_G) & ew_dem_s &
                                    (~ns_dem_s | (nxt_s >= MAX_G)));
    assign ew_go_s = emg_to_ns_s | (~emg_to_ew_s & (nxt_s >= MIN_G) & ns_dem_s &
                                    (~ew_dem_s | (nxt_s >= MAX_G)));

    // Latches clear on entry to their own green; a press on that same clock re-arms for the next green.
    assign ns_ped_pend_s = (ns_enter_s ? 1'b0 : ns_ped_pend_r) | bus.ns_ped_req;
    assign ew_ped_pend_s = (ew_enter_s ? 1'b0 : ew_ped_pend_r) | bus.ew_ped_req;

    // Next state, phase counter and walk qualifier; only illegal-state recovery ignores tick.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        walk_active_s = walk_active_r;
        ns_enter_s    = 1'b0;
        ew_enter_s    = 1'b0;
        if (state_r > RED_TO_NS) begin
            state_s       = NS_GREEN;
            cnt_s         = ZERO_C;
            walk_active_s = 1'b0;
        end else if (bus.tick) begin
            case (state_r)
                NS_GREEN: begin
                    if (ns_go_s) begin
                        state_s       = NS_YELLOW;
                        cnt_s         = ZERO_C;
                        walk_active_s = 1'b0;
                    end else begin
                        cnt_s = grn_cnt_s;
                    end
                end
                NS_YELLOW: begin
                    if (nxt_s == YEL_T) begin
                        state_s = RED_TO_EW;
                        cnt_s   = ZERO_C;
                    end else begin
                        cnt_s = nxt_s[TW-1:0];
                    end
                end
                RED_TO_EW: begin
                    if (nxt_s == RED_T) begin
                        state_s       = EW_GREEN;
                        cnt_s         = ZERO_C;
                        ew_enter_s    = 1'b1;
                        walk_active_s = ew_ped_pend_r;
                    end else begin
                        cnt_s = nxt_s[TW-1:0];
                    end
                end
                EW_GREEN: begin
                    if (ew_go_s) begin
                        state_s       = EW_YELLOW;
                        cnt_s         = ZERO_C;
                        walk_active_s = 1'b0;
                    end else begin
                        cnt_s = grn_cnt_s;
                    end
                end
                EW_YELLOW: begin
                    if (nxt_s == YEL_T) begin
                        state_s = RED_TO_NS;
                        cnt_s   = ZERO_C;
                    end else begin
                        cnt_s = nxt_s[TW-1:0];
                    end
                end
                RED_TO_NS: begin
                    if (nxt_s == RED_T) begin
                        state_s       = NS_GREEN;
                        cnt_s         = ZERO_C;
                        ns_enter_s    = 1'b1;
                        walk_active_s = ns_ped_pend_r;
                    end else begin
                        cnt_s = nxt_s[TW-1:0];
                    end
                end
                default: begin
                    state_s       = NS_GREEN;
                    cnt_s         = ZERO_C;
                    walk_active_s = 1'b0;
                end
            endcase
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Phase state, counter, pedestrian latches and walk qualifier.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= NS_GREEN;
            cnt_r         <= ZERO_C;
            ns_ped_pend_r <= 1'b0;
            ew_ped_pend_r <= 1'b0;
            walk_active_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            ns_ped_pend_r <= ns_ped_pend_s;
            ew_ped_pend_r <= ew_ped_pend_s;
            walk_active_r <= walk_active_s;
        end
    end

    // Lamp decode from the registered state.
    always_comb begin
        bus.ns_light = 3'b100;
        bus.ew_light = 3'b100;
        case (state_r)
            NS_GREEN:  bus.ns_light = 3'b001;
            NS_YELLOW: bus.ns_light = 3'b010;
            EW_GREEN:  bus.ew_light = 3'b001;
            EW_YELLOW: bus.ew_light = 3'b010;
            default: begin
                bus.ns_light = 3'b100;
                bus.ew_light = 3'b100;
            end
        endcase
    end

    assign bus.phase   = state_r;
    assign bus.ns_walk = (state_r == NS_GREEN) & walk_active_r & ({1'b0, cnt_r} < WALK_T) & ~emg_on_s;
    assign bus.ew_walk = (state_r == EW_GREEN) & walk_active_r & ({1'b0, cnt_r} < WALK_T) & ~emg_on_s;
endmodule
